sad_search_ctrl: RTL and testbench
==================================

SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 Parameter DWIDTH, default 8, is the pixel width and SHALL match the SAD engine; sad width is DWIDTH+8.
REQ-002 Parameter CAND_AW, default 4, is the candidate index width.
REQ-003 Parameter NUM_CAND, default 16, is the number of candidates per search, with 1 <= NUM_CAND <= 2^CAND_AW.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a search.
REQ-007 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-008 cand_req  output  1  request for the candidate reference block at cand_addr.
REQ-009 cand_addr  output  CAND_AW  index of the candidate being requested.
REQ-010 cand_rdy  input  1  reference memory presents refi for cand_addr this cycle.
REQ-011 cal_en  output  1  SAD engine sample strobe.
REQ-012 sad  input  DWIDTH+8  SAD engine result.
REQ-013 sad_vld  input  1  SAD engine result valid.
REQ-014 done  output  1  one-cycle pulse when the search completes.
REQ-015 best_sad  output  DWIDTH+8  minimum SAD found.
REQ-016 best_idx  output  CAND_AW  index of the candidate giving best_sad.
REQ-017 early  output  1  search ended by zero-SAD early termination.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE->ISSUE on start=1; on entry, issue_cnt=0, ret_cnt=0, best_sad=all ones, best_idx=0, early=0.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 In ISSUE: cand_req=1 and cand_addr=issue_cnt.
REQ-022 cal_en SHALL be combinational: cand_req & cand_rdy.
REQ-023 Each cycle with cal_en=1, issue_cnt SHALL increment by 1.
REQ-024 cand_addr SHALL hold steady while cand_rdy=0.
REQ-025 ISSUE->DRAIN on the cal_en cycle of candidate NUM_CAND-1, or on the cycle the stop flag sets; cand_req=0 from the next cycle.
REQ-026 Result attribution: on each sad_vld=1 in ISSUE or DRAIN, the result belongs to candidate ret_cnt, and ret_cnt SHALL increment.
REQ-027 The engine returns results in issue order at a fixed latency; the controller SHALL NOT depend on that latency value.
REQ-028 On sad_vld, if sad < best_sad (strict), best_sad<=sad and best_idx<=ret_cnt; ties SHALL keep the lower index.
REQ-029 Early stop: sad_vld with sad==0 SHALL set stop and early=1; no further candidate is issued; already-issued results are still counted.
REQ-030 DRAIN->DONE when ret_cnt==issue_cnt, counting the sad_vld of the current cycle; in DONE, done=1 for exactly one cycle; DONE->IDLE next cycle.
REQ-031 sad_vld SHALL be ignored in IDLE and DONE, with no register change.
REQ-032 best_sad, best_idx and early SHALL hold their final values from DONE until the next accepted start.
REQ-033 Simultaneous sad_vld and cal_en SHALL both take effect in the same cycle.
REQ-034 With NUM_CAND=1, exactly one candidate SHALL be issued.
REQ-035 issue_cnt and ret_cnt SHALL be CAND_AW+1 bits wide, so they never wrap.

Reset
REQ-036 rst=1 at a clock edge SHALL force: state IDLE; busy, cand_req, cal_en, done, early = 0; cand_addr = 0; best_sad = all ones; best_idx = 0; counters = 0.
REQ-037 Reset mid-search SHALL abandon the search with no done pulse; in-flight sad_vld arriving afterwards falls under REQ-031.

Verification
REQ-038 Full search: NUM_CAND=16, cand_rdy=1, results 100-i for i=0..15 -> 16 cal_en, done once, best_sad=85, best_idx=15, early=0.
REQ-039 Backpressure/tie: cand_rdy toggling 1,0,0,1,...; results all 50 -> cand_addr stable while rdy=0, best_idx=0, best_sad=50.
REQ-040 Early stop: result 0 for candidate 3, engine latency 6 -> no cal_en after sad_vld of cand 3, done after ret_cnt equals issued count, best_idx=3, early=1.
REQ-041 Reset at cycle 5 of a search, then new start -> no done pulse for the aborted search; stale sad_vld ignored in IDLE; new search result is correct.
REQ-042 start pulsed while busy=1, and sad_vld pulsed in IDLE -> no state or output change.

Source files
------------

// File: rtl/sad_search_ctrl.sv
// Motion-search controller: issues NUM_CAND candidate fetches to a SAD engine,
// tracks the minimum returned SAD and stops early on a perfect (zero) match.
module sad_search_ctrl #(
  parameter int DWIDTH   = 8,
  parameter int CAND_AW  = 4,
  parameter int NUM_CAND = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               cand_req,
  output logic [CAND_AW-1:0] cand_addr,
  input  logic               cand_rdy,
  output logic               cal_en,
  input  logic [DWIDTH+7:0]  sad,
  input  logic               sad_vld,
  output logic               done,
  output logic [DWIDTH+7:0]  best_sad,
  output logic [CAND_AW-1:0] best_idx,
  output logic               early
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [CAND_AW:0] LAST_CAND = (CAND_AW+1)'(NUM_CAND - 1);

  state_t           state, state_nxt;
  logic [CAND_AW:0] issue_cnt, ret_cnt;
  logic [CAND_AW:0] issue_nxt, ret_nxt;
  logic             res_act, zero_hit;

  always_comb begin
    // NOTE: every signal gets its default first, so no branch can leave one unassigned and infer a latch.
    state_nxt = state;
    busy      = (state != IDLE);
    cand_req  = (state == ISSUE);
    cal_en    = cand_req & cand_rdy;
    done      = (state == DONE);
    cand_addr = issue_cnt[CAND_AW-1:0];
    // Results only count while a search is live; stale ones in IDLE/DONE are dropped.
    res_act   = sad_vld && (state == ISSUE || state == DRAIN);
    zero_hit  = res_act && (sad == '0);
    issue_nxt = issue_cnt + {{CAND_AW{1'b0}}, cal_en};
    ret_nxt   = ret_cnt + {{CAND_AW{1'b0}}, res_act};

    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: if (zero_hit || (cal_en && issue_cnt == LAST_CAND)) state_nxt = DRAIN;
      DRAIN: if (ret_nxt == issue_cnt) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      best_sad  <= '1;
      best_idx  <= '0;
      early     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
            best_sad  <= '1;
            best_idx  <= '0;
            early     <= 1'b0;
          end
        end
        ISSUE, DRAIN: begin
          issue_cnt <= issue_nxt;
          ret_cnt   <= ret_nxt;
          // Strict compare keeps the lower index on ties.
          if (res_act && sad < best_sad) begin
            best_sad <= sad;
            best_idx <= ret_cnt[CAND_AW-1:0];
          end
          if (zero_hit) early <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Randomised bench for sad_search_ctrl: a delay-line SAD engine model feeds the DUT,
// a reference model predicts each search's result and a negedge monitor scores it.
module tb_sad_search_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NC = 16;
  localparam int SW = DW + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cand_rdy = 1'b0;
  logic          busy, cand_req, cal_en, done, early, sad_vld;
  logic [AW-1:0] cand_addr, best_idx;
  logic [SW-1:0] sad, best_sad;

  always #5 clk = ~clk;

  sad_search_ctrl #(.DWIDTH(DW), .CAND_AW(AW), .NUM_CAND(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .cand_req(cand_req),
    .cand_addr(cand_addr), .cand_rdy(cand_rdy), .cal_en(cal_en), .sad(sad),
    .sad_vld(sad_vld), .done(done), .best_sad(best_sad), .best_idx(best_idx),
    .early(early)
  );

  typedef struct packed {logic v; logic [SW-1:0] s;} res_t;
  typedef struct {logic [SW-1:0] sad; logic [AW-1:0] idx; logic early;} exp_t;

  exp_t          exp_q[$];
  exp_t          e, held;
  logic [SW-1:0] sad_tab [NC];
  res_t          pipe [8];
  logic [2:0]    lat_m1 = 3'd0;
  logic          eng_clr = 1'b1;
  logic          inj_vld = 1'b0;
  int            rdy_mode = 0, rdy_phase = 0;
  int            total = 0, bad = 0, done_cnt = 0;
  int            exp_addr = 0, n_issued = 0;
  bit            zero_seen, prev_busy, prev_stall, prev_done, hold_valid;
  logic [AW-1:0] prev_addr;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: fixed-latency delay line, results in issue order.
  always @(posedge clk) begin
    if (eng_clr) begin
      for (int i = 0; i < 8; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {cal_en, sad_tab[cand_addr]};
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign sad_vld = pipe[lat_m1].v | inj_vld;
  assign sad     = inj_vld ? '0 : pipe[lat_m1].s;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: cand_rdy = 1'b1;
      1: begin cand_rdy = (rdy_phase == 0); rdy_phase = (rdy_phase + 1) % 3; end
      default: cand_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference: scan candidates in order; the first zero ends the search.
  function automatic exp_t model();
    exp_t r;
    r.sad = '1; r.idx = '0; r.early = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (sad_tab[i] < r.sad) begin r.sad = sad_tab[i]; r.idx = AW'(i); end
      if (sad_tab[i] == '0) begin r.early = 1'b1; break; end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 0; prev_stall = 0; prev_done = 0;
    end else begin
      if (busy && !prev_busy) begin exp_addr = 0; n_issued = 0; zero_seen = 0; end
      check(cal_en == (cand_req & cand_rdy), "cal_en_comb", longint'(cal_en), longint'(cand_req & cand_rdy));
      if (prev_stall && cand_req)
        check(cand_addr == prev_addr, "addr_hold", longint'(cand_addr), longint'(prev_addr));
      if (cal_en) begin
        check(!zero_seen, "issue_after_zero", longint'(n_issued), 0);
        check(cand_addr == AW'(exp_addr), "issue_order", longint'(cand_addr), longint'(exp_addr));
        exp_addr++; n_issued++;
      end
      if (sad_vld && busy && !done && sad == '0) zero_seen = 1;
      if (prev_done) check(!done, "done_one_cycle", longint'(done), 0);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) check(0, "unexpected_done", longint'(done_cnt), 0);
        else begin
          e = exp_q.pop_front();
          check(best_sad == e.sad, "best_sad", longint'(best_sad), longint'(e.sad));
          check(best_idx == e.idx, "best_idx", longint'(best_idx), longint'(e.idx));
          check(early == e.early, "early", longint'(early), longint'(e.early));
          if (!e.early) check(n_issued == NC, "issue_count", longint'(n_issued), longint'(NC));
          held = e; hold_valid = 1;
        end
      end
      if (!busy && hold_valid)
        check({best_sad, best_idx, early} == {held.sad, held.idx, held.early}, "hold",
              longint'({best_sad, best_idx, early}), longint'({held.sad, held.idx, held.early}));
      prev_busy = busy; prev_stall = cand_req & !cand_rdy; prev_addr = cand_addr; prev_done = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1);
    rst = 1'b1; hold_valid = 0;
    tick(2);
    @(negedge clk);
    check(!busy && !cand_req && !cal_en && !done, "rst_ctrl", longint'({busy, cand_req, cal_en, done}), 0);
    check(!early, "rst_early", longint'(early), 0);
    check(cand_addr == '0, "rst_addr", longint'(cand_addr), 0);
    check(best_sad == '1, "rst_best_sad", longint'(best_sad), longint'((1 << SW) - 1));
    check(best_idx == '0, "rst_best_idx", longint'(best_idx), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    held = '{sad: '1, idx: '0, early: 1'b0};
    hold_valid = 1;
  endtask

  task automatic fill_rand(input int hi, input bit plant_zero);
    for (int i = 0; i < NC; i++) sad_tab[i] = SW'($urandom_range(1, hi));
    if (plant_zero) sad_tab[$urandom_range(0, NC - 1)] = '0;
  endtask

  task automatic run_search(input int mode, input int l, input bit mid_start);
    int  d0;
    bit  got;
    rdy_mode = mode;
    lat_m1 = 3'(l - 1);
    exp_q.push_back(model());
    d0 = done_cnt;
    start = 1'b1; tick(1); start = 1'b0;
    if (mid_start) begin
      tick(3);
      if (busy) begin start = 1'b1; tick(1); start = 1'b0; end
    end
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      tick(1);
      got = (done_cnt != d0);
    end
    check(got, "done_timeout", longint'(done_cnt), longint'(d0 + 1));
    tick(2);
    inj_vld = 1'b1; tick(1); inj_vld = 1'b0;
    tick(2);
  endtask

  initial begin
    int d0;
    do_reset();
    eng_clr = 1'b0;

    for (int i = 0; i < NC; i++) sad_tab[i] = SW'(100 - i);
    run_search(0, 3, 0);

    for (int i = 0; i < NC; i++) sad_tab[i] = SW'(50);
    rdy_phase = 0;
    run_search(1, 2, 1);

    fill_rand(500, 0);
    sad_tab[3] = '0;
    run_search(0, 6, 0);

    // Abort mid-search; late results from the engine land in IDLE.
    fill_rand(300, 0);
    lat_m1 = 3'd6; rdy_mode = 0;
    exp_q.push_back(model());
    start = 1'b1; tick(1); start = 1'b0;
    tick(4);
    d0 = done_cnt;
    void'(exp_q.pop_back());
    do_reset();
    tick(12);
    check(done_cnt == d0, "abort_no_done", longint'(done_cnt), longint'(d0));
    fill_rand(300, 0);
    run_search(2, 5, 0);

    repeat (24) begin
      fill_rand(($urandom_range(0, 1) != 0) ? 6 : 600, $urandom_range(0, 3) == 0);
      run_search($urandom_range(0, 2), $urandom_range(1, 7), $urandom_range(0, 1) != 0);
    end

    check(exp_q.size() == 0, "scoreboard_empty", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
